// File: rtl/store_buffer_if.sv
// Store-request and memory-write bundle shared by the store buffer and its environment.
// The slave modport is the store buffer; the master modport is the core/memory side.
interface store_buffer_if #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [CW-1:0] count;
    logic          busy;

    modport slave (
        input  st_valid, st_addr, st_data, mem_ack,
        output st_ready, mem_req, mem_we, mem_addr, mem_wdata, count, busy
    );

    modport master (
        output st_valid, st_addr, st_data, mem_ack,
        input  st_ready, mem_req, mem_we, mem_addr, mem_wdata, count, busy
    );
endinterface

// File: rtl/store_buffer.sv
// Small in-order FIFO of {address, data} stores drained to data memory over a req/ack handshake.
// count includes the entry currently presented on the memory port.
module store_buffer #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_st_ready;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_ptr_nxt;

    // Ready looks only at the registered count, so a same-edge pop never frees a slot.
    assign w_st_ready   = (r_count < CW'(DEPTH));
    assign w_push       = bus.st_valid && w_st_ready;
    assign w_pop        = (r_state == ST_REQ) && bus.mem_ack;
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(1);

    // NOTE: storage array has no reset; occupancy is tracked by r_count, so stale
    // contents are never presented and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.st_addr;
            r_fifo_data[r_wr_ptr] <= bus.st_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                        r_mem_wdata <= r_fifo_data[r_rd_ptr];
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The next entry is only chained if it was queued before this edge;
                    // a push landing with the last ack waits for a pass through IDLE.
                    if (bus.mem_ack) begin
                        if (r_count > CW'(1)) begin
                            r_mem_addr  <= r_fifo_addr[w_rd_ptr_nxt];
                            r_mem_wdata <= r_fifo_data[w_rd_ptr_nxt];
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.st_ready  = w_st_ready;
    assign bus.mem_req   = (r_state == ST_REQ);
    assign bus.mem_we    = (r_state == ST_REQ);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.count     = r_count;
    assign bus.busy      = (r_count != '0);
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations on timing and on the order of completed writes.
module tb_store_buffer;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

    store_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mq holds every accepted, not yet acknowledged store, oldest first.
    // m_pres says whether the oldest one is currently offered to memory.
    entry_t mq[$];
    bit     m_pres = 1'b0;
    bit     m_init = 1'b0;

    always @(posedge clk) begin
        bit m_pop;
        bit m_push;
        bit m_pres_n;
        int sz;
        if (!rst) begin
            mq.delete();
            m_pres = 1'b0;
            m_init = 1'b1;
        end else begin
            sz     = mq.size();
            m_pop  = m_pres && (bus.mem_ack === 1'b1);
            m_push = (bus.st_valid === 1'b1) && (sz < DEPTH);
            if (m_pop)        m_pres_n = (sz > 1);
            else if (!m_pres) m_pres_n = (sz > 0);
            else              m_pres_n = 1'b1;
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back('{a: bus.st_addr, d: bus.st_data});
            m_pres = m_pres_n;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("mem_req",  32'(bus.mem_req),  32'(m_pres));
            check("mem_we",   32'(bus.mem_we),   32'(m_pres));
            check("count",    32'(bus.count),    32'(mq.size()));
            check("busy",     32'(bus.busy),     32'(mq.size() != 0));
            check("st_ready", 32'(bus.st_ready), 32'(mq.size() < DEPTH));
            if (m_pres) begin
                check("mem_addr",  32'(bus.mem_addr),  32'(mq[0].a));
                check("mem_wdata", 32'(bus.mem_wdata), 32'(mq[0].d));
            end
        end
    end

    // Writes the DUT completes, in order, for literal order checks.
    entry_t wlog[$];
    always @(posedge clk) begin
        if (rst && bus.mem_req && bus.mem_ack)
            wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.st_valid = 1'b0;
    endtask

    int guard;
    int n0;
    bit rdy;

    initial begin
        bus.st_valid = 1'b1;
        bus.st_addr  = 16'h0BAD;
        bus.st_data  = 16'hBEEF;
        bus.mem_ack  = 1'b1;

        // Reset held for two edges with stimulus active.
        rst = 1'b0;
        tick();
        tick();
        check("rst_count",    32'(bus.count),     32'd0);
        check("rst_mem_req",  32'(bus.mem_req),   32'd0);
        check("rst_mem_we",   32'(bus.mem_we),    32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        check("rst_wdata",    32'(bus.mem_wdata), 32'd0);
        check("rst_busy",     32'(bus.busy),      32'd0);
        bus.st_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_release_ready", 32'(bus.st_ready), 32'd1);

        // Single store, ack delayed.
        wlog.delete();
        push(16'h0010, 16'h0006);
        check("single_lat_n",  32'(bus.mem_req), 32'd0);
        tick();
        check("single_req",    32'(bus.mem_req),   32'd1);
        check("single_addr",   32'(bus.mem_addr),  32'h0010);
        check("single_data",   32'(bus.mem_wdata), 32'h0006);
        tick();
        tick();
        check("single_hold_a", 32'(bus.mem_addr),  32'h0010);
        check("single_hold_d", 32'(bus.mem_wdata), 32'h0006);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("single_done_req",   32'(bus.mem_req), 32'd0);
        check("single_done_count", 32'(bus.count),   32'd0);
        check("single_log_n",      32'(wlog.size()), 32'd1);

        // Fill to full, fifth offer held off, then drain in order.
        wlog.delete();
        for (int i = 1; i <= 4; i++) push(16'(16'h0100 + i), 16'(i));
        check("full_count", 32'(bus.count),    32'd4);
        check("full_ready", 32'(bus.st_ready), 32'd0);
        bus.st_valid = 1'b1;
        bus.st_addr  = 16'h0105;
        bus.st_data  = 16'h0005;
        tick();
        check("full_refused_count", 32'(bus.count), 32'd4);
        bus.mem_ack = 1'b1;
        guard = 0;
        while (bus.st_valid && guard < 20) begin
            rdy = bus.st_ready;
            tick();
            if (rdy) bus.st_valid = 1'b0;
            guard++;
        end
        check("fill_accept_5", 32'(bus.st_valid), 32'd0);
        guard = 0;
        while (bus.busy && guard < 20) begin
            tick();
            guard++;
        end
        check("fill_drained", 32'(bus.busy), 32'd0);
        bus.mem_ack = 1'b0;
        check("fill_log_n", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            check("fill_order_d", 32'(wlog[i].d), 32'(i + 1));
            check("fill_order_a", 32'(wlog[i].a), 32'(16'h0101 + i));
        end

        // Back-to-back drain with ack held high.
        push(16'h0201, 16'h00A1);
        push(16'h0202, 16'h00A2);
        push(16'h0203, 16'h00A3);
        check("b2b_first", 32'(bus.mem_wdata), 32'h00A1);
        bus.mem_ack = 1'b1;
        tick();
        check("b2b_second_req", 32'(bus.mem_req),   32'd1);
        check("b2b_second",     32'(bus.mem_wdata), 32'h00A2);
        tick();
        check("b2b_third",      32'(bus.mem_wdata), 32'h00A3);
        tick();
        check("b2b_end_req",    32'(bus.mem_req),   32'd0);
        bus.mem_ack = 1'b0;

        // Push and pop on the same edge at count=2.
        wlog.delete();
        push(16'h0301, 16'h00B1);
        push(16'h0302, 16'h00B2);
        check("pp2_pre_count", 32'(bus.count), 32'd2);
        bus.mem_ack = 1'b1;
        push(16'h0303, 16'h00B3);
        check("pp2_count", 32'(bus.count),     32'd2);
        check("pp2_data",  32'(bus.mem_wdata), 32'h00B2);
        tick();
        tick();
        bus.mem_ack = 1'b0;
        check("pp2_log_n", 32'(wlog.size()), 32'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            check("pp2_order", 32'(wlog[i].d), 32'(16'h00B1 + i));

        // Push on the ack edge of the last entry: one idle cycle.
        push(16'h0401, 16'h00C1);
        tick();
        check("pp1_pre_count", 32'(bus.count), 32'd1);
        bus.mem_ack = 1'b1;
        push(16'h0402, 16'h00C2);
        bus.mem_ack = 1'b0;
        check("pp1_idle_req",   32'(bus.mem_req), 32'd0);
        check("pp1_idle_count", 32'(bus.count),   32'd1);
        tick();
        check("pp1_issue_req",  32'(bus.mem_req),   32'd1);
        check("pp1_issue_data", 32'(bus.mem_wdata), 32'h00C2);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("pp1_done", 32'(bus.count), 32'd0);

        // Reset in the middle of a transfer.
        push(16'h0501, 16'h00D1);
        push(16'h0502, 16'h00D2);
        push(16'h0503, 16'h00D3);
        check("midrst_pre_req", 32'(bus.mem_req), 32'd1);
        n0 = wlog.size();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        check("midrst_count", 32'(bus.count),   32'd0);
        check("midrst_req",   32'(bus.mem_req), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("midrst_quiet_req", 32'(bus.mem_req), 32'd0);
        check("midrst_no_writes", 32'(wlog.size()), 32'(n0));
        bus.mem_ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
